// File: rtl/serial_frame_gen_pkg.sv
// Shared types and constants for the serial frame generator.
// Build option PARITY_EN adds an even-parity bit between the data bits and the stop bit.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Bits per frame: start + payload (+ parity) + stop.
    function automatic int frame_bits(input int data_w);
`ifdef PARITY_EN
        return data_w + 3;
`else
        return data_w + 2;
`endif
    endfunction

endpackage

// File: rtl/serial_frame_gen_if.sv
// Word-in / bit-out bundle of the serial frame generator, plus a state debug tap.
// Build option PARITY_EN changes only the frame length, not this bundle.
interface serial_frame_gen_if #(
    parameter int DATA_W = 8
);
    import serial_frame_pkg::*;

    // Handshake: a word is accepted on a rising clk edge where din_vld and din_rdy
    // are both 1. The source keeps din and din_vld stable until that edge;
    // din_vld while din_rdy is 0 has no effect. din_rdy never depends on din_vld.
    logic [DATA_W-1:0] din;
    logic              din_vld;
    logic              din_rdy;
    logic              ser_out;
    logic              shift_o;
    state_e            dbg_state;

    modport master (
        output din, din_vld,
        input  din_rdy, ser_out, shift_o, dbg_state
    );

    modport slave (
        input  din, din_vld,
        output din_rdy, ser_out, shift_o, dbg_state
    );

endinterface

// File: rtl/serial_frame_gen_bit_period_ctr.sv
// Bit-period timer: counts DIV clocks per bit while the frame generator is active.
// first = a new bit period starts next clock, last = this is the final clock of a period.
module bit_period_ctr #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic first,
    output logic last
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt_q;
    logic          active_q;
    logic          wrap;

    assign wrap  = (div_cnt_q == CNT_LAST);
    assign last  = active_q && wrap;
    // run is the generator's next-state activity, so a period starting after idle is seen here too.
    assign first = run && (!active_q || wrap);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            active_q  <= 1'b0;
        end else if (!run) begin
            div_cnt_q <= '0;
            active_q  <= 1'b0;
        end else begin
            active_q  <= 1'b1;
            div_cnt_q <= (!active_q || wrap) ? '0 : div_cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/serial_frame_gen.sv
// Serialises accepted words into start / MSB-first data / stop frames with an active-low load strobe.
// Define PARITY_EN to insert an even-parity bit (^din at accept) before the stop bit.
module serial_frame_gen
    import serial_frame_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV    = 4
) (
    input  logic              clk,
    input  logic              rst,
    serial_frame_gen_if.slave bus
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q;
    logic [BW-1:0]     bit_cnt_q;
    logic              ser_out_q;
    logic              shift_q;
    logic              run, first, last;
    logic              din_rdy, accept;
`ifdef PARITY_EN
    logic              parity_q;
`endif

    assign din_rdy = (state_q == IDLE) || (state_q == STOP && last);
    assign accept  = bus.din_vld && din_rdy;
    assign run     = (state_d != IDLE);

    bit_period_ctr #(.DIV(DIV)) u_bit_period_ctr (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .first (first),
        .last  (last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (accept) state_d = START;
            START:  if (last) state_d = DATA;
            DATA: begin
                if (last && bit_cnt_q == LAST_BIT) begin
`ifdef PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef PARITY_EN
            PARITY: if (last) state_d = STOP;
`endif
            STOP:   if (last) state_d = accept ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            ser_out_q <= LINE_IDLE;
            shift_q   <= 1'b1;
`ifdef PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= ~first;
            if (accept) begin
                shreg_q <= bus.din;
`ifdef PARITY_EN
                parity_q <= ^bus.din;
`endif
            end
            // Output bit and data bookkeeping change only at a bit-period boundary.
            if (first) begin
                bit_cnt_q <= (state_q == DATA && state_d == DATA) ? bit_cnt_q + BW'(1) : '0;
                case (state_d)
                    START:  ser_out_q <= START_BIT;
                    DATA: begin
                        ser_out_q <= shreg_q[DATA_W-1];
                        shreg_q   <= shreg_q << 1;
                    end
`ifdef PARITY_EN
                    PARITY: ser_out_q <= parity_q;
`endif
                    STOP:   ser_out_q <= STOP_BIT;
                    default: ser_out_q <= LINE_IDLE;
                endcase
            end else if (state_d == IDLE) begin
                ser_out_q <= LINE_IDLE;
                bit_cnt_q <= '0;
            end
        end
    end

    assign bus.din_rdy   = din_rdy;
    assign bus.ser_out   = ser_out_q;
    assign bus.shift_o   = shift_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_serial_frame_gen.sv
// Bench for serial_frame_gen: DIV=4 and DIV=1 instances checked bit by bit against a frame queue.
// Expected frame length follows PARITY_EN when the bench is built with it.
module tb_serial_frame_gen;
    import serial_frame_pkg::*;

    localparam int DATA_W = 8;
    localparam int DIV    = 4;
`ifdef PARITY_EN
    localparam int NB = DATA_W + 3;
`else
    localparam int NB = DATA_W + 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [0:0] exp_q[$];

    serial_frame_gen_if #(.DATA_W(DATA_W)) sif ();
    serial_frame_gen_if #(.DATA_W(DATA_W)) fif ();

    serial_frame_gen #(.DATA_W(DATA_W), .DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    serial_frame_gen #(.DATA_W(DATA_W), .DIV(1)) dut_fast (
        .clk (clk),
        .rst (rst),
        .bus (fif)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_frame(input logic [DATA_W-1:0] d);
        exp_q.push_back(1'b0);
        for (int i = DATA_W - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef PARITY_EN
        exp_q.push_back(^d);
`endif
        exp_q.push_back(1'b1);
    endtask

    // Call just after a negedge; returns #1 after the accept edge with din_vld still high.
    task automatic accept_word(input bit fast, input logic [DATA_W-1:0] d);
        bit ok = 1'b0;
        if (fast) begin fif.din = d; fif.din_vld = 1'b1; end
        else      begin sif.din = d; sif.din_vld = 1'b1; end
        for (int i = 0; i < 200; i++) begin
            if ((fast ? fif.din_rdy : sif.din_rdy) === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL accept_wait: din_rdy=0, required 1 within 200 clks");
        end
        @(posedge clk);
        push_frame(d);
        #1;
    endtask

    task automatic test_reset();
        sif.din = '0; sif.din_vld = 1'b0;
        fif.din = '0; fif.din_vld = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks += 4;
        if (sif.ser_out !== 1'b1) begin n_fail++; $display("FAIL reset_ser_out: got %b, required 1", sif.ser_out); end
        if (sif.shift_o !== 1'b1) begin n_fail++; $display("FAIL reset_shift_o: got %b, required 1", sif.shift_o); end
        if (sif.din_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_din_rdy: got %b, required 1", sif.din_rdy); end
        if (fif.ser_out !== 1'b1) begin n_fail++; $display("FAIL reset_fast_ser_out: got %b, required 1", fif.ser_out); end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks += 4;
            if (sif.ser_out !== 1'b1) begin n_fail++; $display("FAIL idle_ser_out c=%0d: got %b, required 1", c, sif.ser_out); end
            if (sif.shift_o !== 1'b1) begin n_fail++; $display("FAIL idle_shift_o c=%0d: got %b, required 1", c, sif.shift_o); end
            if (sif.din_rdy !== 1'b1) begin n_fail++; $display("FAIL idle_din_rdy c=%0d: got %b, required 1", c, sif.din_rdy); end
            if (sif.dbg_state !== IDLE) begin n_fail++; $display("FAIL idle_state c=%0d: got %0d, required %0d", c, sif.dbg_state, IDLE); end
        end
    endtask

    // One DIV=4 frame; with inject, a busy-time word is offered and must be ignored.
    task automatic test_frame(input logic [DATA_W-1:0] d, input bit inject, input string name);
        logic [0:0] eb = 1'b1;
        int nc = NB * DIV;
        @(negedge clk);
        accept_word(1'b0, d);
        sif.din_vld = 1'b0;
        for (int c = 0; c < nc; c++) begin
            @(negedge clk);
            if (c % DIV == 0) eb = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            n_checks += 3;
            if (sif.ser_out !== eb)
                begin n_fail++; $display("FAIL %s_ser_out c=%0d: got %b, required %b", name, c + 1, sif.ser_out, eb); end
            if (sif.shift_o !== (c % DIV != 0))
                begin n_fail++; $display("FAIL %s_shift_o c=%0d: got %b, required %b", name, c + 1, sif.shift_o, (c % DIV != 0)); end
            if (sif.din_rdy !== (c == nc - 1))
                begin n_fail++; $display("FAIL %s_din_rdy c=%0d: got %b, required %b", name, c + 1, sif.din_rdy, (c == nc - 1)); end
            if (inject && c == 9)  begin sif.din = 8'h3C; sif.din_vld = 1'b1; end
            if (inject && c == 20) sif.din_vld = 1'b0;
        end
        @(negedge clk);
        n_checks += 2;
        if (sif.ser_out !== 1'b1) begin n_fail++; $display("FAIL %s_after_ser_out: got %b, required 1", name, sif.ser_out); end
        if (sif.shift_o !== 1'b1) begin n_fail++; $display("FAIL %s_after_shift_o: got %b, required 1", name, sif.shift_o); end
    endtask

    task automatic test_single_frame();
        test_frame(8'hA5, 1'b0, "single");
    endtask

    task automatic test_busy_ignore();
        test_frame(8'hA5, 1'b1, "busy");
    endtask

    task automatic test_back_to_back();
        logic [0:0] eb = 1'b1;
        int nc = NB * DIV;
        @(negedge clk);
        accept_word(1'b0, 8'h00);
        sif.din = 8'hFF;
        push_frame(8'hFF);
        for (int c = 0; c < 2 * nc; c++) begin
            @(negedge clk);
            if (c % DIV == 0) eb = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            n_checks += 3;
            if (sif.ser_out !== eb)
                begin n_fail++; $display("FAIL b2b_ser_out c=%0d: got %b, required %b", c + 1, sif.ser_out, eb); end
            if (sif.shift_o !== (c % DIV != 0))
                begin n_fail++; $display("FAIL b2b_shift_o c=%0d: got %b, required %b", c + 1, sif.shift_o, (c % DIV != 0)); end
            if (sif.din_rdy !== (c == nc - 1 || c == 2 * nc - 1))
                begin n_fail++; $display("FAIL b2b_din_rdy c=%0d: got %b, required %b", c + 1, sif.din_rdy, (c == nc - 1 || c == 2 * nc - 1)); end
            if (c == nc) sif.din_vld = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (sif.dbg_state !== IDLE) begin n_fail++; $display("FAIL b2b_end_state: got %0d, required %0d", sif.dbg_state, IDLE); end
    endtask

    task automatic test_reset_mid_frame();
        logic [0:0] eb = 1'b1;
        @(negedge clk);
        accept_word(1'b0, 8'hA5);
        sif.din_vld = 1'b0;
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            if (c % DIV == 0) eb = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            n_checks++;
            if (sif.ser_out !== eb)
                begin n_fail++; $display("FAIL midrst_ser_out c=%0d: got %b, required %b", c + 1, sif.ser_out, eb); end
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks += 4;
        if (sif.ser_out !== 1'b1) begin n_fail++; $display("FAIL midrst_abort_ser_out: got %b, required 1", sif.ser_out); end
        if (sif.shift_o !== 1'b1) begin n_fail++; $display("FAIL midrst_abort_shift_o: got %b, required 1", sif.shift_o); end
        if (sif.din_rdy !== 1'b1) begin n_fail++; $display("FAIL midrst_abort_din_rdy: got %b, required 1", sif.din_rdy); end
        if (sif.dbg_state !== IDLE) begin n_fail++; $display("FAIL midrst_abort_state: got %0d, required %0d", sif.dbg_state, IDLE); end
        rst = 1'b0;
        exp_q.delete();
        test_frame(8'h81, 1'b0, "after_rst");
    endtask

    task automatic test_div1(input logic [DATA_W-1:0] d, input string name);
        logic [0:0] eb;
        @(negedge clk);
        accept_word(1'b1, d);
        fif.din_vld = 1'b0;
        for (int c = 0; c < NB; c++) begin
            @(negedge clk);
            eb = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            n_checks += 3;
            if (fif.ser_out !== eb)
                begin n_fail++; $display("FAIL %s_ser_out c=%0d: got %b, required %b", name, c + 1, fif.ser_out, eb); end
            if (fif.shift_o !== 1'b0)
                begin n_fail++; $display("FAIL %s_shift_o c=%0d: got %b, required 0", name, c + 1, fif.shift_o); end
            if (fif.din_rdy !== (c == NB - 1))
                begin n_fail++; $display("FAIL %s_din_rdy c=%0d: got %b, required %b", name, c + 1, fif.din_rdy, (c == NB - 1)); end
        end
        @(negedge clk);
        n_checks += 2;
        if (fif.ser_out !== 1'b1) begin n_fail++; $display("FAIL %s_after_ser_out: got %b, required 1", name, fif.ser_out); end
        if (fif.shift_o !== 1'b1) begin n_fail++; $display("FAIL %s_after_shift_o: got %b, required 1", name, fif.shift_o); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_frame();
        test_div1(8'h5A, "div1_5a");
        test_div1(8'h07, "div1_07");
        test_div1(8'($urandom_range(0, 255)), "div1_rand");
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL queue_drain: %0d bits left, required 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
